// File: rtl/conv.sv
// Streaming KxK "valid" convolution (stride 1/2) over a 3-row line buffer with a multi-cycle MAC.
// Define CONV_RELU_EN to clamp negative results to zero on entry to OUTPUT.
module conv #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MULT_PER_CYCLE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [9*DATA_WIDTH-1:0] weights,
  input  logic [9*DATA_WIDTH-1:0] biases,
  input  logic                    stride,
  input  logic [DATA_WIDTH-1:0]   newPixelData,
  input  logic                    new_data_valid,
  input  logic                    out_accepting_values,
  input  logic [7:0]              input_dim,
  input  logic [1:0]              window_dim,
  output logic [31:0]             result,
  output logic                    resultValid,
  output logic                    idle_out
);
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned AW   = 32;
  localparam int unsigned TAPS = 9;
  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 256;
  localparam int unsigned MPC  = MULT_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT} state_t;
  state_t state_q, state_d;

  logic [7:0]      row_q, col_q, n_q, base_col_q;
  logic [1:0]      slot_q, k_q, base_slot_q;
  logic            s_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   acc_q;
  logic [9*DW-1:0] weights_q, biases_q;
  logic [DW-1:0]   line_mem [ROWS][COLS];

  logic       first_px, accept, win_done, last_col, last_row, cnt_done;
  logic [7:0] eff_n, km1;
  logic [1:0] eff_k;
  logic       eff_s;
  logic [3:0] kk, ncyc;
  logic [2:0] bsum;
  logic [1:0] bslot;

  // Frame geometry is taken from the ports only on the first pixel of a frame
  always_comb begin
    first_px = (row_q == 8'd0) && (col_q == 8'd0);
    accept   = idle_out && new_data_valid;
    eff_n    = first_px ? input_dim : n_q;
    eff_k    = first_px ? ((window_dim == 2'd0) ? 2'd3 : window_dim) : k_q;
    eff_s    = first_px ? stride : s_q;
    km1      = 8'(eff_k) - 8'd1;
    win_done = (row_q >= km1) && (col_q >= km1) &&
               (!eff_s || (((row_q[0] ^ km1[0]) == 1'b0) && ((col_q[0] ^ km1[0]) == 1'b0)));
    last_col = (col_q == (eff_n - 8'd1));
    last_row = (row_q == (eff_n - 8'd1));
    kk       = 4'(k_q) * 4'(k_q);
    ncyc     = 4'((32'(kk) + MPC - 32'd1) / MPC);
    cnt_done = (cnt_q == ncyc);
    bsum     = 3'(slot_q) + 3'd3 - 3'(km1);
    bslot    = (bsum >= 3'd3) ? 2'(bsum - 3'd3) : 2'(bsum);
  end

  logic [DW-1:0] w_arr [TAPS];
  logic [DW-1:0] b_arr [TAPS];

  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) begin
      w_arr[i] = weights_q[i*DW +: DW];
      b_arr[i] = biases_q[i*DW +: DW];
    end
  end

  // MAC lanes: tap t maps to window row t/K, column t%K; oldest row lives at base_slot_q
  int unsigned   t, r, c, sl, tap;
  logic [7:0]    ci;
  logic [AW-1:0] wx, px, bx, acc_d;

  always_comb begin
    acc_d = acc_q;
    t     = 0;
    r     = 0;
    c     = 0;
    sl    = 0;
    tap   = 0;
    ci    = '0;
    wx    = '0;
    px    = '0;
    bx    = '0;
    for (int unsigned m = 0; m < MPC; m++) begin
      t = 32'(cnt_q) * MPC + m;
      if (t < 32'(kk)) begin
        case (k_q)
          2'd1:    begin r = t;     c = 0;     end
          2'd2:    begin r = t / 2; c = t % 2; end
          default: begin r = t / 3; c = t % 3; end
        endcase
        sl = 32'(base_slot_q) + r;
        if (sl >= ROWS) sl = sl - ROWS;
        ci    = base_col_q + 8'(c);
        tap   = 32'd8 - (r * 32'd3 + c);
        wx    = {{(AW-DW){w_arr[4'(tap)][DW-1]}}, w_arr[4'(tap)]};
        px    = {{(AW-DW){1'b0}}, line_mem[2'(sl)][ci]};
        bx    = {{(AW-DW){b_arr[4'(tap)][DW-1]}}, b_arr[4'(tap)]};
        acc_d = acc_d + wx * px + bx;
      end
    end
  end

  logic [AW-1:0] res_next;

  always_comb begin
`ifdef CONV_RELU_EN
    res_next = acc_q[AW-1] ? '0 : acc_q;
`else
    res_next = acc_q;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept && win_done) state_d = S_COMPUTE;
      S_COMPUTE: if (cnt_done) state_d = S_OUTPUT;
      S_OUTPUT:  if (out_accepting_values) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idle_out    <= 1'b1;
      resultValid <= 1'b0;
      result      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      slot_q      <= '0;
      n_q         <= '0;
      k_q         <= 2'd3;
      s_q         <= 1'b0;
      base_slot_q <= '0;
      base_col_q  <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      weights_q   <= '0;
      biases_q    <= '0;
    end else begin
      state_q  <= state_d;
      idle_out <= (state_d == S_IDLE);
      if (accept) begin
        if (first_px) begin
          n_q <= eff_n;
          k_q <= eff_k;
          s_q <= eff_s;
        end
        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q  <= '0;
            slot_q <= '0;
          end else begin
            row_q  <= row_q + 8'd1;
            slot_q <= (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
          end
        end else begin
          col_q <= col_q + 8'd1;
        end
        if (win_done) begin
          base_slot_q <= bslot;
          base_col_q  <= col_q - km1;
          cnt_q       <= '0;
          acc_q       <= '0;
          weights_q   <= weights;
          biases_q    <= biases;
        end
      end
      if (state_q == S_COMPUTE) begin
        if (!cnt_done) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 4'd1;
        end else begin
          result      <= res_next;
          resultValid <= 1'b1;
        end
      end
      if ((state_q == S_OUTPUT) && out_accepting_values) resultValid <= 1'b0;
    end
  end

  // Line buffer storage needs no reset: rows are only read once written this frame
  always_ff @(posedge clock) begin
    if (accept) line_mem[slot_q][col_q] <= newPixelData;
  end

endmodule

// File: tb/tb_conv.sv
// Directed bench for conv: flat/ramp Sobel frames, stride 2, backpressure, K=1 biases, mid-compute reset.
module tb_conv;
  localparam logic [71:0] SOBEL = {8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'hFF, 8'hFE, 8'hFF};

  logic        clock = 1'b0;
  logic        reset;
  logic [71:0] weights, biases;
  logic        stride;
  logic [7:0]  newPixelData;
  logic        new_data_valid;
  logic        out_accepting_values;
  logic [7:0]  input_dim;
  logic [1:0]  window_dim;
  logic [31:0] result;
  logic        resultValid;
  logic        idle_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  conv #(.DATA_WIDTH(8), .MULT_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .weights(weights), .biases(biases), .stride(stride),
    .newPixelData(newPixelData), .new_data_valid(new_data_valid),
    .out_accepting_values(out_accepting_values), .input_dim(input_dim),
    .window_dim(window_dim), .result(result), .resultValid(resultValid), .idle_out(idle_out)
  );

  // A result is consumed on the edge following a cycle with valid and ready both high
  always @(negedge clock) begin
    if (resultValid && out_accepting_values) got_q.push_back(result);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle_out && n < 100) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(idle_out), 32'd1);
  endtask

  task automatic send(input logic [7:0] p);
    wait_idle();
    newPixelData   = p;
    new_data_valid = 1'b1;
    step();
    new_data_valid = 1'b0;
  endtask

  task automatic drain();
    wait_idle();
    repeat (2) step();
  endtask

  // 4x4 vertical ramp: pixel = row*10
  task automatic send_ramp(input int first, input int last);
    for (int i = first; i <= last; i++) send(8'((i / 4) * 10));
  endtask

  task automatic chk_list(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic fill_exp(input int n, input logic [31:0] v);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial begin
    int n;
    int v;
    logic [31:0] r0;
    logic stable;

    reset = 1'b0;
    weights = SOBEL;
    biases = '0;
    stride = 1'b0;
    newPixelData = '0;
    new_data_valid = 1'b0;
    out_accepting_values = 1'b1;
    input_dim = 8'd4;
    window_dim = 2'd3;
    repeat (3) step();
    chk("rst_result", result, 32'd0);
    chk("rst_valid", 32'(resultValid), 32'd0);
    chk("rst_idle", 32'(idle_out), 32'd1);
    reset = 1'b1;
    step();

    // Flat frame, plus latency of the first window
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      send(8'd100);
      if (i == 10) begin
        n = 0;
        while (!resultValid && n < 40) begin
          step();
          n++;
        end
        chk("latency", 32'(n), 32'd10);
      end
    end
    drain();
    fill_exp(4, 32'd0);
    chk_list("flat");

    // Ramp frame; geometry changes after the first pixel must be ignored
    got_q.delete();
    send_ramp(0, 0);
    input_dim = 8'd5;
    window_dim = 2'd1;
    stride = 1'b1;
    send_ramp(1, 15);
    drain();
    fill_exp(4, 32'hFFFF_FFB0);
    chk_list("ramp");

    // Stride 2 on 7x7: top-left + bottom-right taps give 2*(16r+c)+34 at origin (r,c)
    got_q.delete();
    weights = {8'd1, 56'd0, 8'd1};
    input_dim = 8'd7;
    window_dim = 2'd3;
    stride = 1'b1;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) send(8'(r * 16 + c));
    drain();
    exp_q.delete();
    for (int r = 0; r < 5; r += 2)
      for (int c = 0; c < 5; c += 2) exp_q.push_back(32'(2 * (16 * r + c) + 34));
    chk_list("stride2");

    // Backpressure on the first ramp window
    got_q.delete();
    weights = SOBEL;
    input_dim = 8'd4;
    stride = 1'b0;
    out_accepting_values = 1'b0;
    send_ramp(0, 10);
    n = 0;
    while (!resultValid && n < 40) begin
      step();
      n++;
    end
    chk("bp_valid_seen", 32'(resultValid), 32'd1);
    r0 = result;
    stable = 1'b1;
    repeat (20) begin
      step();
      if (result !== r0 || resultValid !== 1'b1 || idle_out !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_value", r0, 32'hFFFF_FFB0);
    chk("bp_idle_low", 32'(idle_out), 32'd0);
    out_accepting_values = 1'b1;
    step();
    chk("bp_valid_drop", 32'(resultValid), 32'd0);
    chk("bp_idle_back", 32'(idle_out), 32'd1);
    send_ramp(11, 15);
    drain();
    fill_exp(4, 32'hFFFF_FFB0);
    chk_list("bp");

    // K=1 with bias: result 3p-5
    got_q.delete();
    weights = {8'd3, 64'd0};
    biases = {8'hFB, 64'd0};
    window_dim = 2'd1;
    input_dim = 8'd3;
    for (int p = 0; p < 9; p++) send(8'(p));
    drain();
    exp_q.delete();
    for (int p = 0; p < 9; p++) begin
      v = 3 * p - 5;
`ifdef CONV_RELU_EN
      if (v < 0) v = 0;
`endif
      exp_q.push_back(32'(v));
    end
    chk_list("k1");

    // Reset while computing: no result, then a clean frame
    weights = SOBEL;
    biases = '0;
    window_dim = 2'd3;
    input_dim = 8'd4;
    send_ramp(0, 10);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 32'(resultValid), 32'd0);
    step();
    reset = 1'b1;
    got_q.delete();
    repeat (15) step();
    chk("mid_rst_no_result", 32'(got_q.size()), 32'd0);
    chk("mid_rst_idle", 32'(idle_out), 32'd1);
    send_ramp(0, 15);
    drain();
    fill_exp(4, 32'hFFFF_FFB0);
    chk_list("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
